// File: rtl/approx_cla_pipe_adder.sv
// approx_cla_pipe_adder
//   Pipelined carry-lookahead adder. The WIDTH-bit addition is split into
//   BLOCK-bit CLA slices, one slice per pipeline stage. Within the
//   APPROX_BITS least-significant bits an approximate carry (propagate term
//   dropped) can be selected per transaction with approx_en_i.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   in_valid_i   operands valid           in_ready_o   adder can accept operands
//   add1_i       operand A                add2_i       operand B
//   approx_en_i  1 = approximate LSBs, sampled with the operands
//   out_valid_o  result valid             out_ready_i  consumer accepts result
//   result_o     {carry-out, sum}
//   err_o        (only with APPROX_ERR_FLAG_EN) result differs from exact sum
//
// Build option
//   `define APPROX_ERR_FLAG_EN adds err_o and a shadow exact datapath.
module approx_cla_pipe_adder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned BLOCK       = 4,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             approx_en_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o
`ifdef APPROX_ERR_FLAG_EN
  ,
  output logic             err_o
`endif
);

  localparam int unsigned S = WIDTH / BLOCK;

  // Register level 0 holds the captured operands; level k+1 holds the
  // result of slice k. Level S is the output register.
  logic [WIDTH-1:0] st_a   [0:S-1];
  logic [WIDTH-1:0] st_b   [0:S-1];
  logic             st_apx [0:S-1];
  logic [WIDTH-1:0] st_sum [0:S];
  logic             st_c   [0:S];
  logic             st_vld [0:S];

  logic [WIDTH-1:0] nxt_sum [0:S-1];
  logic             nxt_c   [0:S-1];
  logic [BLOCK:0]   sl;

`ifdef APPROX_ERR_FLAG_EN
  logic [WIDTH-1:0] st_xsum  [0:S];
  logic             st_xc    [0:S];
  logic [WIDTH-1:0] nxt_xsum [0:S-1];
  logic             nxt_xc   [0:S-1];
  logic [BLOCK:0]   xsl;
`endif

  logic advance;

  // One CLA slice. Approximate bits get a zero carry-propagate so their
  // carry-out is just a&b. The approximate sum XNOR(XNOR(a,b),c) equals
  // a^b^c, so the sum expression is shared by both modes.
  function automatic logic [BLOCK:0] slice_add(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input int unsigned      k,
    input logic             apx,
    input logic             cin
  );
    logic [BLOCK-1:0] sa, sb, g, p, t;
    logic [BLOCK:0]   c;
    logic             acc_g, acc_p;
    sa = BLOCK'(a >> (k * BLOCK));
    sb = BLOCK'(b >> (k * BLOCK));
    g  = sa & sb;
    p  = sa ^ sb;
    t  = p;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      if (apx && (APPROX_BITS > k * BLOCK + i)) t[i] = 1'b0;
    end
    c    = '0;
    c[0] = cin;
    // Lookahead form: c[i+1] = G[i:0] | P[i:0] & cin, built as sum of products.
    for (int unsigned i = 0; i < BLOCK; i++) begin
      acc_g = 1'b0;
      acc_p = 1'b1;
      for (int unsigned j = 0; j <= i; j++) begin
        acc_g = acc_g | (acc_p & g[i-j]);
        acc_p = acc_p & t[i-j];
      end
      c[i+1] = acc_g | (acc_p & cin);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  assign advance    = out_ready_i | ~out_valid_o;
  assign in_ready_o = advance;

  always_comb begin
    sl = '0;
    for (int unsigned k = 0; k < S; k++) begin
      sl         = slice_add(st_a[k], st_b[k], k, st_apx[k], st_c[k]);
      // Upper sum bits are still zero at this level, so OR-ing inserts the slice.
      nxt_sum[k] = st_sum[k] | (WIDTH'(sl[BLOCK-1:0]) << (k * BLOCK));
      nxt_c[k]   = sl[BLOCK];
    end
  end

`ifdef APPROX_ERR_FLAG_EN
  always_comb begin
    xsl = '0;
    for (int unsigned k = 0; k < S; k++) begin
      xsl         = slice_add(st_a[k], st_b[k], k, 1'b0, st_xc[k]);
      nxt_xsum[k] = st_xsum[k] | (WIDTH'(xsl[BLOCK-1:0]) << (k * BLOCK));
      nxt_xc[k]   = xsl[BLOCK];
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k <= S; k++) begin
        st_vld[k] <= 1'b0;
        st_sum[k] <= '0;
        st_c[k]   <= 1'b0;
`ifdef APPROX_ERR_FLAG_EN
        st_xsum[k] <= '0;
        st_xc[k]   <= 1'b0;
`endif
      end
      for (int unsigned k = 0; k < S; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_apx[k] <= 1'b0;
      end
    end else if (advance) begin
      st_vld[0] <= in_valid_i;
      st_a[0]   <= add1_i;
      st_b[0]   <= add2_i;
      st_apx[0] <= approx_en_i;
      st_sum[0] <= '0;
      st_c[0]   <= 1'b0;
`ifdef APPROX_ERR_FLAG_EN
      st_xsum[0] <= '0;
      st_xc[0]   <= 1'b0;
`endif
      for (int unsigned k = 0; k < S; k++) begin
        st_vld[k+1] <= st_vld[k];
        st_sum[k+1] <= nxt_sum[k];
        st_c[k+1]   <= nxt_c[k];
`ifdef APPROX_ERR_FLAG_EN
        st_xsum[k+1] <= nxt_xsum[k];
        st_xc[k+1]   <= nxt_xc[k];
`endif
      end
      for (int unsigned k = 1; k < S; k++) begin
        st_a[k]   <= st_a[k-1];
        st_b[k]   <= st_b[k-1];
        st_apx[k] <= st_apx[k-1];
      end
    end
  end

  assign out_valid_o = st_vld[S];
  assign result_o    = {st_c[S], st_sum[S]};

`ifdef APPROX_ERR_FLAG_EN
  assign err_o = ({st_c[S], st_sum[S]} != {st_xc[S], st_xsum[S]});
`endif

endmodule

// File: tb/tb_approx_cla_pipe_adder.sv
// Self-checking bench for approx_cla_pipe_adder: directed vectors, a stall
// scenario, mid-operation reset and randomized traffic against a
// cycle-level reference built from plain arithmetic.
module tb_approx_cla_pipe_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned BLK = 4;
  localparam int unsigned AB  = 4;
  localparam int unsigned S   = W / BLK;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          in_valid_i, in_ready_o, approx_en_i, out_valid_o, out_ready_i;
  logic [W-1:0]  add1_i, add2_i;
  logic [W:0]    result_o;

  logic          in_valid32, in_ready32, out_valid32;
  logic [31:0]   add1_32, add2_32;
  logic [32:0]   result32;

`ifdef APPROX_ERR_FLAG_EN
  logic err_o, err32;
`endif

  always #5 clk = ~clk;

  approx_cla_pipe_adder #(.WIDTH(W), .BLOCK(BLK), .APPROX_BITS(AB)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .approx_en_i(approx_en_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o)
`ifdef APPROX_ERR_FLAG_EN
    , .err_o(err_o)
`endif
  );

  approx_cla_pipe_adder #(.WIDTH(32), .BLOCK(8), .APPROX_BITS(0)) u_dut32 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
    .add1_i(add1_32), .add2_i(add2_32), .approx_en_i(1'b1),
    .out_valid_o(out_valid32), .out_ready_i(1'b1), .result_o(result32)
`ifdef APPROX_ERR_FLAG_EN
    , .err_o(err32)
`endif
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: approximate rule applied bit by bit over the low AB bits,
  // plain addition above with the low-region carry fed in.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic apx);
    logic [W:0] low_part, hi;
    logic       c, ai, bi, s;
    low_part = '0;
    c        = 1'b0;
    for (int i = 0; i < int'(AB); i++) begin
      ai = a[i];
      bi = b[i];
      if (apx) begin
        s = ~(~(ai ^ bi) ^ c);
        c = ai & bi;
      end else begin
        s = ai ^ bi ^ c;
        c = (ai & bi) | (ai & c) | (bi & c);
      end
      low_part[i] = s;
    end
    hi = ({1'b0, a} >> AB) + ({1'b0, b} >> AB) + (W+1)'(c);
    return (hi << AB) | low_part;
  endfunction

  typedef struct {
    logic       v;
    logic [W:0] r;
    logic       e;
  } slot_t;

  // Expected contents of the S+1 register levels between accept and output.
  slot_t m [0:S];

  // One clock cycle: drive at negedge, check against the model, then advance
  // the model as the coming rising edge will.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic apx, input logic ordy, input logic rst,
                      output logic acc);
    logic       adv;
    logic [W:0] r;
    @(negedge clk);
    rst_i       = rst;
    in_valid_i  = v;
    add1_i      = a;
    add2_i      = b;
    approx_en_i = apx;
    out_ready_i = ordy;
    #1;
    adv = ordy | ~m[S].v;
    check("in_ready", in_ready_o, adv);
    check("out_valid", out_valid_o, m[S].v);
    if (m[S].v) begin
      check("result", result_o, m[S].r);
`ifdef APPROX_ERR_FLAG_EN
      check("err", err_o, m[S].e);
`endif
    end
    acc = 1'b0;
    if (rst) begin
      for (int k = 0; k <= int'(S); k++) m[k].v = 1'b0;
    end else if (adv) begin
      for (int k = int'(S); k > 0; k--) m[k] = m[k-1];
      r    = ref_sum(a, b, apx);
      m[0] = '{v: v, r: r, e: (r != ({1'b0, a} + {1'b0, b}))};
      acc  = v;
    end
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_result", result_o, '0);
    check("rst_in_ready", in_ready_o, 1'b1);
`ifdef APPROX_ERR_FLAG_EN
    check("rst_err", err_o, 1'b0);
`endif
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic apx,
                          input logic [W:0] exp_r, input logic exp_e);
    int n;
    @(negedge clk);
    in_valid_i  = 1'b1;
    add1_i      = a;
    add2_i      = b;
    approx_en_i = apx;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, S);
    check("dir_result", result_o, exp_r);
`ifdef APPROX_ERR_FLAG_EN
    check("dir_err", err_o, exp_e);
`else
    if (exp_e === 1'bx) $display("unexpected flag");
`endif
    @(posedge clk);
    #1;
    check("valid_pulse", out_valid_o, 1'b0);
  endtask

  initial begin
    logic          acc;
    logic [W-1:0]  sa [0:7];
    logic [W-1:0]  sb [0:7];
    int            idx, n;

    for (int k = 0; k <= int'(S); k++) m[k] = '{v: 1'b0, r: '0, e: 1'b0};
    rst_i = 1'b1; in_valid_i = 1'b0; add1_i = '0; add2_i = '0;
    approx_en_i = 1'b0; out_ready_i = 1'b1;
    in_valid32 = 1'b0; add1_32 = '0; add2_32 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_i = 1'b0;

    directed(16'h29AF, 16'h7A1B, 1'b0, 17'h0A3CA, 1'b0);
    directed(16'h29AF, 16'h7A1B, 1'b1, 17'h0A3C2, 1'b1);
    directed(16'h8943, 16'hFFFF, 1'b1, 17'h1893A, 1'b1);
    directed(16'h5555, 16'hAAAA, 1'b1, 17'h0FFFF, 1'b0);

    // Wide configuration, exact only.
    @(negedge clk);
    in_valid32 = 1'b1; add1_32 = 32'hFFFF_FFFF; add2_32 = 32'h1;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    n = 0;
    while (!out_valid32 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat32", n, 4);
    check("result32", result32, 33'h1_0000_0000);
`ifdef APPROX_ERR_FLAG_EN
    check("err32", err32, 1'b0);
`endif

    // Eight back-to-back pairs with the consumer stalled in cycles 6-9.
    for (int i = 0; i < 8; i++) begin
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      if (idx < 8) step(1'b1, sa[idx], sb[idx], idx[0], !(c >= 6 && c <= 9), 1'b0, acc);
      else         step(1'b0, '0, '0, 1'b0, !(c >= 6 && c <= 9), 1'b0, acc);
      if (acc) idx++;
    end
    check("stream_accepted", idx, 8);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    @(posedge clk);
    #1;
    check_reset_state();
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

    // Randomized traffic with random backpressure; includes all-ones/zero edges.
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 9) == 0) ra = '1;
      if ($urandom_range(0, 9) == 0) rb = '1;
      if ($urandom_range(0, 19) == 0) ra = '0;
      step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_cla_pipe_adder.md
# approx_cla_pipe_adder

Parametrised, pipelined successor to the 16-bit XNOR-based carry-lookahead adder. It splits a WIDTH-bit addition into BLOCK-bit carry-lookahead slices, one slice per pipeline stage. Within the APPROX_BITS least-significant bits it can apply an approximate carry, selectable per transaction. It sits between operand producers and consumers in the approximate-arithmetic datapath, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand width; must be a multiple of BLOCK.
- BLOCK, 4, bits per CLA slice and per pipeline stage; S = WIDTH/BLOCK stages.
- APPROX_BITS, 4, LSBs eligible for approximation; range 0..WIDTH.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  adder can accept operands.
- add1_i  input  WIDTH  operand A.
- add2_i  input  WIDTH  operand B.
- approx_en_i  input  1  1 = approximate LSBs, 0 = exact; sampled with the operands.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH+1  sum; the MSB is the carry-out.

## Operation
- Accept: an input is accepted when in_valid_i & in_ready_o. A result is consumed when out_valid_o & out_ready_i.
- Exact bit i: g=a&b, p=a^b, s_i = p ^ c_i, c_{i+1} = g | (p & c_i). Carry-in to bit 0 is 0.
- Approximate bit i (i < APPROX_BITS and approx_en=1):
  - s_i = XNOR(XNOR(a_i,b_i), c_i).
  - c_{i+1} = a_i & b_i. The propagate term is dropped.
- Bits ≥ APPROX_BITS are always exact. The carry out of the approximate region feeds them unchanged.
- Stage k (0..S-1) computes slice bits [k*BLOCK +: BLOCK] from the registered carry of stage k-1. It uses CLA logic inside the slice; approximate bits inside a slice use the approximate carry rule.
- Each stage registers:
  - the remaining operand bits,
  - the sum bits computed so far,
  - the slice carry-out,
  - approx_en,
  - a valid bit.
- The final stage writes {carry, sum} to result_o.
- Stall: the whole pipeline advances only when out_ready_i | ~out_valid_o. in_ready_o equals that same term, registered nowhere.
- Bubbles are not squeezed out; invalid stages advance like valid ones.
- result_o holds its value while out_valid_o=1 and out_ready_i=0.

## Timing
- Latency: S cycles from the accept edge to out_valid_o=1, with no stall. For the defaults that is 4.
- Throughput: one result per cycle when out_ready_i=1.
- Reset values: every stage valid=0, out_valid_o=0, result_o=0. in_ready_o=1 in the first cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded, none reach the output, and nothing is retried.
- Simultaneous accept and consume under backpressure: when out_valid_o=1 and out_ready_i=1, a new input is accepted in the same cycle and the pipeline shifts.
- Full pipeline with out_ready_i=0: in_ready_o=0. Inputs are ignored and the stage contents are frozen.
- APPROX_BITS=0, or approx_en_i=0: the result is bit-exact, add1_i+add2_i.

## Configuration
- APPROX_ERR_FLAG_EN defined:
  - An extra output err_o (1 bit) is added.
  - An exact sum is carried alongside the approximate sum through the pipeline.
  - err_o = (result_o != exact sum), valid when out_valid_o=1, and 0 after reset.
  - err_o is always 0 when approx_en=0.
- APPROX_ERR_FLAG_EN undefined: no err_o port and no shadow exact datapath.

## Test plan
- Defaults, approx_en_i=0, A=16'h29AF, B=16'h7A1B, out_ready_i=1 -> 4 cycles later result_o=17'h0A3CA, out_valid_o=1 for one cycle.
- approx_en_i=1, A=16'h29AF, B=16'h7A1B -> result_o=17'h0A3C2; err_o=1 if the flag is enabled.
- approx_en_i=1, A=16'h8943, B=16'hFFFF -> result_o=17'h1893A, err_o=1. Then A=16'h5555, B=16'hAAAA -> 17'h0FFFF, err_o=0.
- Back-to-back stream of 8 operand pairs with out_ready_i held 0 for cycles 6-9:
  - in_ready_o=0 while full;
  - the results are in order, none lost or duplicated;
  - result_o is stable during the stall.
- rst_i asserted with 3 transactions in flight -> the next cycle has out_valid_o=0 and result_o=0; no stale result ever appears.
- WIDTH=32, BLOCK=8, APPROX_BITS=0: A=32'hFFFFFFFF, B=32'h1 -> after 4 cycles result_o=33'h100000000.
